tcdm_bank_rr_arb: RTL and testbench
===================================

Name: tcdm_bank_rr_arb

Overview:
- Bank-side stage directly downstream of the per-master address decoders.
- Collects the decoded one-bit requests that all masters aim at one TCDM bank and picks one per cycle by round-robin.
- Forwards the winner's request data to the bank and returns a same-cycle grant to that master.
- Tracks the winner through the bank read latency and raises a per-master read-valid strobe.
- One instance per bank.

Parameters:
- NumMaster, 8: number of requesting masters, >=1, need not be a power of 2.
- ReqDataWidth, 32: width of request payload (addr/wen/be/wdata bundle).
- RespLat, 1: bank read latency in cycles, >=1; must equal the decoders' RespLat.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NumMaster  decoded request from each master.
- data_i  in  NumMaster x ReqDataWidth  payload from each master.
- gnt_o  out  NumMaster  one-hot grant to the winning master.
- rvld_o  out  NumMaster  one-hot response-valid, RespLat cycles after handshake.
- req_o  out  1  request to bank.
- data_o  out  ReqDataWidth  winner's payload to bank.
- gnt_i  in  1  bank accept, combinational, may depend on req_o.
- idx_o  out  IdxW  index of current winner; IdxW = max(1, clog2(NumMaster)).

Behaviour:
- Reset (async, rst_ni=0): rr pointer = 0, response pipeline cleared. rvld_o = 0 during and after reset until a new handshake matures. Combinational outputs follow inputs.
- req_o = OR of req_i.
- Winner selection:
  - Winner = first asserted req_i at index >= ptr_q, scanning upward.
  - If none, the lowest asserted index below ptr_q (wrap).
  - If no request: idx_o = 0, data_o = data_i[0].
- data_o = data_i[winner]; idx_o = winner.
- gnt_o[winner] = req_o & gnt_i; all other bits 0. Zero-latency, same cycle as request.
- Handshake = req_o & gnt_i.
- Pointer update:
  - On handshake: ptr_d = winner+1, wrapping to 0 when winner = NumMaster-1. Explicit compare, not bit truncation, so non-power-of-2 works.
  - No handshake (idle, or bank stall gnt_i=0): pointer holds, so a stalled winner stays the winner next cycle unless it drops req.
- Response tracking:
  - Shift register of RespLat stages, each NumMaster-bit one-hot.
  - Stage 0 loads gnt_o every cycle.
  - Stage k loads stage k-1.
  - rvld_o = last stage.
  - Back-to-back grants are pipelined, one per cycle, no bubbles.
- Masters may drop req_i without a grant. The arbiter must not assume request persistence, and no pointer change occurs.
- NumMaster = 1: pointer fixed at 0, idx_o = 0, gnt_o = gnt_i & req_i[0].
- Mid-operation reset clears in-flight rvld immediately. Bank-side responses for those transactions are dropped.
- No X on outputs when req_i is all zero.

Decomposition:
- Shared package tcdm_interco_pkg:
  - function idx_width(n) returning max(1, clog2(n)).
  - typedef for the request payload bundle, sized by ReqDataWidth.
- Sub-module rr_find_first (combinational): inputs req vector and ptr; outputs winner index and a found flag; masks req with (index >= ptr), falls back to the unmasked leading-one search.
- Pointer register and response shift register stay in the top module.

Test Plan:
1. NumMaster=4, RespLat=1, req_i=1111 held, gnt_i=1 for 8 cycles -> gnt_o sequence 0001,0010,0100,1000,0001,...; rvld_o the same sequence delayed one cycle; data_o tracks data_i[idx_o] each cycle.
2. req_i=0110, ptr=2 (after granting 1), gnt_i=0 for 3 cycles then 1 -> idx_o=2 all four cycles, gnt_o=0000 then 0100; ptr becomes 3; rvld_o=0100 one cycle later.
3. NumMaster=5, only req_i[4] for 1 handshake then req_i=10001 -> grant to 4, ptr wraps to 0, next grant to 0 then 4.
4. RespLat=3, grants to masters 0,2,1 on consecutive cycles -> rvld_o = 001,100,010 on cycles +3,+4,+5, zero otherwise.
5. Assert rst_ni=0 one cycle after grant with RespLat=2 -> rvld_o never pulses for that grant; ptr=0, next req_i=1111 grants master 0.
6. req_i all zero, gnt_i=1 -> req_o=0, gnt_o=0, ptr unchanged, rvld_o=0 RespLat later.

Source files
------------

// File: rtl/tcdm_interco_pkg.sv
// tcdm_interco_pkg: shared types and helpers for the TCDM interconnect
package tcdm_interco_pkg;
  localparam int DefaultReqDataWidth = 32;
  typedef logic [DefaultReqDataWidth-1:0] req_data_t;
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tcdm_bank_rr_arb_find_first.sv
// rr_find_first: lowest request at or above ptr, else lowest request overall
module rr_find_first #(
  parameter int N    = 8,
  parameter int IdxW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            found_o
);
  logic [N-1:0]    masked;
  logic [IdxW-1:0] idx_m, idx_u;
  always_comb begin
    masked = '0;
    idx_m  = '0;
    idx_u  = '0;
    for (int i = 0; i < N; i++) masked[i] = req_i[i] & (IdxW'(i) >= ptr_i);
    for (int i = N - 1; i >= 0; i--) begin
      idx_m = masked[i] ? IdxW'(i) : idx_m;
      idx_u = req_i[i] ? IdxW'(i) : idx_u;
    end
    found_o = |req_i;
    idx_o   = |masked ? idx_m : idx_u;
  end
endmodule

// File: rtl/tcdm_bank_rr_arb.sv
// tcdm_bank_rr_arb: per-bank round-robin arbiter with read-valid tracking
module tcdm_bank_rr_arb
  import tcdm_interco_pkg::*;
#(
  parameter int NumMaster    = 8,
  parameter int ReqDataWidth = 32,
  parameter int RespLat      = 1,
  localparam int IdxW        = idx_width(NumMaster)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumMaster-1:0]                  req_i,
  input  logic [NumMaster-1:0][ReqDataWidth-1:0] data_i,
  output logic [NumMaster-1:0]                  gnt_o,
  output logic [NumMaster-1:0]                  rvld_o,
  output logic                                  req_o,
  output logic [ReqDataWidth-1:0]               data_o,
  input  logic                                  gnt_i,
  output logic [IdxW-1:0]                       idx_o
);
  logic [IdxW-1:0]                   ptr_q, ptr_d, win;
  logic                              found, hs;
  logic [RespLat-1:0][NumMaster-1:0] rsp_q, rsp_d;
  logic [RespLat:0][NumMaster-1:0]   rsp_sh;
  rr_find_first #(.N(NumMaster), .IdxW(IdxW)) u_ff (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .idx_o  (win),
    .found_o(found)
  );
  assign req_o  = |req_i;
  assign hs     = req_o & gnt_i;
  assign idx_o  = found ? win : '0;
  assign data_o = data_i[idx_o];
  assign gnt_o  = hs ? (NumMaster'(1) << idx_o) : '0;
  // explicit wrap compare keeps non-power-of-2 master counts correct
  assign ptr_d  = hs ? ((idx_o == IdxW'(NumMaster - 1)) ? '0 : idx_o + IdxW'(1)) : ptr_q;
  assign rsp_sh = {rsp_q, gnt_o};
  assign rsp_d  = rsp_sh[RespLat-1:0];
  assign rvld_o = rsp_q[RespLat-1];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      rsp_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rsp_q <= rsp_d;
    end
  end
endmodule

// File: tb/tb_tcdm_bank_rr_arb.sv
// tb_tcdm_bank_rr_arb: scoreboard bench for the bank round-robin arbiter
module tb_tcdm_bank_rr_arb;
  import tcdm_interco_pkg::*;
  localparam int N  = 5;
  localparam int L  = 3;
  localparam int W  = 16;
  localparam int IW = idx_width(N);
  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic [N-1:0]          req_i, gnt_o, rvld_o;
  logic [N-1:0][W-1:0]   data_i;
  logic                  req_o, gnt_i;
  logic [W-1:0]          data_o;
  logic [IW-1:0]         idx_o;
  int                    n_run, n_fail, ptr_m, exp_w;
  logic [N-1:0]          exp_g, exp_r;
  logic [N-1:0]          exp_q[$];
  tcdm_bank_rr_arb #(.NumMaster(N), .ReqDataWidth(W), .RespLat(L)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (req_i),
    .data_i(data_i),
    .gnt_o (gnt_o),
    .rvld_o(rvld_o),
    .req_o (req_o),
    .data_o(data_o),
    .gnt_i (gnt_i),
    .idx_o (idx_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic int model_win(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction
  task automatic reset_model();
    ptr_m = 0;
    exp_q.delete();
    repeat (L) exp_q.push_back('0);
  endtask
  task automatic apply(input logic [N-1:0] r, input logic g);
    req_i = r;
    gnt_i = g;
    for (int i = 0; i < N; i++) data_i[i] = W'($urandom);
    #1;
    exp_w = model_win(r, ptr_m);
    exp_g = (|r && g) ? (N'(1) << exp_w) : '0;
    exp_r = exp_q.pop_front();
  endtask
  task automatic commit();
    exp_q.push_back(exp_g);
    if (|exp_g) ptr_m = (exp_w == N - 1) ? 0 : exp_w + 1;
    @(posedge clk_i);
    #1;
  endtask
  task automatic test_reset();
    rst_ni = 1'b0;
    req_i  = '0;
    gnt_i  = 1'b0;
    data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    n_run++;
    if (rvld_o !== '0) begin n_fail++; $display("FAIL reset_rvld got %b want %b", rvld_o, {N{1'b0}}); end
    n_run++;
    if (req_o !== 1'b0 || gnt_o !== '0 || idx_o !== '0)
      begin n_fail++; $display("FAIL reset_idle got req=%b gnt=%b idx=%0d want 0/0/0", req_o, gnt_o, idx_o); end
    rst_ni = 1'b1;
    reset_model();
  endtask
  task automatic test_rotation();
    for (int c = 0; c < 12; c++) begin
      apply('1, 1'b1);
      n_run++;
      if (gnt_o !== exp_g || idx_o !== IW'(exp_w))
        begin n_fail++; $display("FAIL rot_gnt c%0d got %b/%0d want %b/%0d", c, gnt_o, idx_o, exp_g, exp_w); end
      n_run++;
      if (data_o !== data_i[exp_w] || req_o !== 1'b1)
        begin n_fail++; $display("FAIL rot_data c%0d got %h/%b want %h/1", c, data_o, req_o, data_i[exp_w]); end
      n_run++;
      if (rvld_o !== exp_r) begin n_fail++; $display("FAIL rot_rvld c%0d got %b want %b", c, rvld_o, exp_r); end
      commit();
    end
  endtask
  task automatic test_stall();
    apply(5'b00010, 1'b1);
    commit();
    for (int c = 0; c < 4; c++) begin
      apply(5'b00110, c == 3);
      n_run++;
      if (idx_o !== IW'(2) || gnt_o !== exp_g)
        begin n_fail++; $display("FAIL stall c%0d got idx=%0d gnt=%b want 2/%b", c, idx_o, gnt_o, exp_g); end
      n_run++;
      if (rvld_o !== exp_r) begin n_fail++; $display("FAIL stall_rvld c%0d got %b want %b", c, rvld_o, exp_r); end
      commit();
    end
  endtask
  task automatic test_wrap();
    logic [N-1:0] rq[3];
    logic [N-1:0] want[3];
    rq   = '{5'b10000, 5'b10001, 5'b10001};
    want = '{5'b10000, 5'b00001, 5'b10000};
    for (int c = 0; c < 3; c++) begin
      apply(rq[c], 1'b1);
      n_run++;
      if (gnt_o !== want[c]) begin n_fail++; $display("FAIL wrap c%0d got %b want %b", c, gnt_o, want[c]); end
      n_run++;
      if (rvld_o !== exp_r) begin n_fail++; $display("FAIL wrap_rvld c%0d got %b want %b", c, rvld_o, exp_r); end
      commit();
    end
  endtask
  task automatic test_pipeline();
    logic [N-1:0] rq[8];
    rq = '{5'b00001, 5'b00100, 5'b00010, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
    for (int c = 0; c < 8; c++) begin
      apply(rq[c], 1'b1);
      n_run++;
      if (gnt_o !== rq[c]) begin n_fail++; $display("FAIL pipe_gnt c%0d got %b want %b", c, gnt_o, rq[c]); end
      n_run++;
      if (rvld_o !== exp_r) begin n_fail++; $display("FAIL pipe_rvld c%0d got %b want %b", c, rvld_o, exp_r); end
      commit();
    end
  endtask
  task automatic test_midreset();
    apply(5'b00100, 1'b1);
    commit();
    for (int c = 0; c < 2; c++) begin
      apply('0, 1'b0);
      commit();
    end
    apply('0, 1'b0);
    n_run++;
    if (rvld_o !== 5'b00100) begin n_fail++; $display("FAIL mid_pre got %b want 00100", rvld_o); end
    rst_ni = 1'b0;
    #1;
    n_run++;
    if (rvld_o !== '0) begin n_fail++; $display("FAIL mid_clear got %b want 00000", rvld_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    reset_model();
    for (int c = 0; c < L + 1; c++) begin
      apply(c == 0 ? '1 : '0, 1'b1);
      n_run++;
      if (c == 0 && gnt_o !== 5'b00001) begin n_fail++; $display("FAIL mid_ptr got %b want 00001", gnt_o); end
      n_run++;
      if (rvld_o !== exp_r) begin n_fail++; $display("FAIL mid_rvld c%0d got %b want %b", c, rvld_o, exp_r); end
      commit();
    end
  endtask
  task automatic test_idle();
    apply(5'b00100, 1'b1);
    commit();
    for (int c = 0; c < L + 2; c++) begin
      apply(c == 2 ? '1 : '0, 1'b1);
      if (c < 2) begin
        n_run++;
        if (req_o !== 1'b0 || gnt_o !== '0 || idx_o !== '0 || data_o !== data_i[0])
          begin n_fail++; $display("FAIL idle c%0d got req=%b gnt=%b idx=%0d data=%h", c, req_o, gnt_o, idx_o, data_o); end
      end else begin
        n_run++;
        if (gnt_o !== exp_g) begin n_fail++; $display("FAIL idle_ptr c%0d got %b want %b", c, gnt_o, exp_g); end
      end
      n_run++;
      if (rvld_o !== exp_r) begin n_fail++; $display("FAIL idle_rvld c%0d got %b want %b", c, rvld_o, exp_r); end
      commit();
    end
  endtask
  initial begin
    n_run  = 0;
    n_fail = 0;
    test_reset();
    test_rotation();
    test_stall();
    test_wrap();
    test_pipeline();
    test_midreset();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
